// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width, idle line level and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle of each bit.
// clear_i restarts the count at the beginning of a frame.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop; valid/ready input.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
module transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      serial_out,
    output logic                      busy,
    output uart_state_e               state_dbg
);

    // Handshake: a byte is taken when tx_valid && tx_ready at a rising edge;
    // tx_ready never depends on tx_valid, and valid while not ready is ignored.
    uart_state_e               state_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [2:0]                bit_cnt_q;
    logic                      serial_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    logic bit_end;
    logic accept;

    assign tx_ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state_q != IDLE);
    assign serial_out = serial_q;
    assign state_dbg  = state_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept),
        .en_i     (busy),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    serial_q <= UART_IDLE_LEVEL;
                    if (accept) begin
                        state_q   <= START;
                        shift_q   <= data_in;
                        bit_cnt_q <= '0;
                        serial_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= uart_even_parity(data_in);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q  <= DATA;
                        serial_q <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q  <= PARITY;
                            serial_q <= parity_q;
`else
                            state_q  <= STOP;
                            serial_q <= 1'b1;
`endif
                        end else begin
                            // serial_q follows the bit that becomes shift_q[0] after this shift.
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            serial_q  <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q  <= STOP;
                        serial_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (accept) begin
                            state_q   <= START;
                            shift_q   <= data_in;
                            bit_cnt_q <= '0;
                            serial_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_q  <= uart_even_parity(data_in);
`endif
                        end else begin
                            state_q  <= IDLE;
                            serial_q <= UART_IDLE_LEVEL;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
